vector_mem_sequencer: RTL and testbench

//  Sequences whole-vector loads and stores through the 3-port data memory (dataMemory): one beat per cycle, 3 elements/beat.

---
 rtl/vector_mem_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// Strided whole-vector load/store sequencer in front of a 3-port data memory.
// Each beat covers three consecutive elements (one per memory lane). Load
// data is gathered into a vector buffer. The sequencer is the only master of
// the memory while busy.
module vector_mem_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MAX_LEN = 12,
  parameter int LEN_W   = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,     // active-low, asynchronous
  input  logic                      start_i,
  input  logic                      is_store_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [ADDR_W-1:0]         stride_i,
  input  logic [LEN_W-1:0]          vlen_i,
  input  logic [MAX_LEN*DATA_W-1:0] st_vector_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [MAX_LEN*DATA_W-1:0] ld_vector_o,
  output logic [ADDR_W-1:0]         mem_pos1_o,
  output logic [ADDR_W-1:0]         mem_pos2_o,
  output logic [ADDR_W-1:0]         mem_pos3_o,
  output logic [DATA_W-1:0]         mem_wd1_o,
  output logic [DATA_W-1:0]         mem_wd2_o,
  output logic [DATA_W-1:0]         mem_wd3_o,
  output logic                      mem_oe_o,
  output logic                      mem_wen_o,
  input  logic [DATA_W-1:0]         mem_rd1_i,
  input  logic [DATA_W-1:0]         mem_rd2_i,
  input  logic [DATA_W-1:0]         mem_rd3_i
);

  // Element counters need headroom past MAX_LEN for the "one beat beyond" value.
  localparam int EW = LEN_W + 1;
  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [EW-1:0]       len_q;
  logic [EW-1:0]       elem_q;
  logic                busy_q, done_q, oe_q, wen_q;
  logic [DATA_W-1:0]   st_q   [MAX_LEN];
  logic [DATA_W-1:0]   ld_q   [MAX_LEN];
  logic [ADDR_W-1:0]   pos_q  [3];
  logic [DATA_W-1:0]   wd_q   [3];

  logic [DATA_W-1:0]   st_in  [MAX_LEN];
  logic [DATA_W-1:0]   rd_in  [3];
  logic [EW-1:0]       vlen_c;

  // Next-beat lane values and current-beat capture qualifiers.
  logic [ADDR_W-1:0]   beat_addr, beat_stride;
  logic [EW-1:0]       beat_elem, beat_len;
  logic                beat_store, beat_more;
  logic [EW-1:0]       lane_elem [3];
  logic                lane_ok   [3];
  logic [EW-1:0]       lane_src  [3];
  logic [ADDR_W-1:0]   pos_d     [3];
  logic [DATA_W-1:0]   wd_d      [3];
  logic [EW-1:0]       cap_idx   [3];
  logic                cap_ok    [3];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_pack
      assign st_in[gi] = st_vector_i[gi*DATA_W +: DATA_W];
      assign ld_vector_o[gi*DATA_W +: DATA_W] = ld_q[gi];
    end
  endgenerate

  assign rd_in[0] = mem_rd1_i;
  assign rd_in[1] = mem_rd2_i;
  assign rd_in[2] = mem_rd3_i;

  assign vlen_c = ({1'b0, vlen_i} > EW'(MAX_LEN)) ? EW'(MAX_LEN) : {1'b0, vlen_i};

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_oe_o   = oe_q;
  assign mem_wen_o  = wen_q;
  assign mem_pos1_o = pos_q[0];
  assign mem_pos2_o = pos_q[1];
  assign mem_pos3_o = pos_q[2];
  assign mem_wd1_o  = wd_q[0];
  assign mem_wd2_o  = wd_q[1];
  assign mem_wd3_o  = wd_q[2];

  // Lane addresses/data for the beat that follows the next edge: beat 0 from
  // the request inputs when idle, otherwise the beat after the current one.
  always_comb begin
    beat_addr   = addr_q + ADDR_W'(3) * stride_q;
    beat_stride = stride_q;
    beat_elem   = elem_q + EW'(3);
    beat_len    = len_q;
    beat_store  = (state_q == S_STORE);
    if (state_q == S_IDLE) begin
      beat_addr   = base_addr_i;
      beat_stride = stride_i;
      beat_elem   = '0;
      beat_len    = vlen_c;
      beat_store  = is_store_i;
    end
    beat_more = (beat_elem < beat_len);
    for (int n = 0; n < 3; n++) begin
      lane_elem[n] = beat_elem + EW'(n);
      lane_ok[n]   = (lane_elem[n] < beat_len);
      // Unused tail lanes mirror lane 1 so a duplicate write is harmless.
      pos_d[n]     = lane_ok[n] ? beat_addr + ADDR_W'(n) * beat_stride : beat_addr;
      lane_src[n]  = lane_ok[n] ? lane_elem[n] : beat_elem;
      wd_d[n]      = '0;
      if (beat_store && (lane_src[n] < EW'(MAX_LEN))) begin
        wd_d[n] = (state_q == S_IDLE) ? st_in[lane_src[n][AW-1:0]]
                                      : st_q[lane_src[n][AW-1:0]];
      end
      cap_idx[n] = elem_q + EW'(n);
      cap_ok[n]  = (cap_idx[n] < len_q);
    end
  end

  // Request latch, beat sequencing, load gather and registered memory outputs.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      elem_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      wen_q    <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        st_q[i] <= '0;
        ld_q[i] <= '0;
      end
      for (int n = 0; n < 3; n++) begin
        pos_q[n] <= '0;
        wd_q[n]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            addr_q   <= base_addr_i;
            stride_q <= stride_i;
            len_q    <= vlen_c;
            elem_q   <= '0;
            busy_q   <= 1'b1;
            for (int i = 0; i < MAX_LEN; i++) begin
              st_q[i] <= st_in[i];
              if (!is_store_i && (EW'(i) >= vlen_c)) ld_q[i] <= '0;
            end
            if (vlen_c == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= is_store_i ? S_STORE : S_LOAD;
              oe_q    <= ~is_store_i;
              wen_q   <= is_store_i;
              pos_q   <= pos_d;
              wd_q    <= wd_d;
            end
          end
        end
        S_LOAD, S_STORE: begin
          if (state_q == S_LOAD) begin
            for (int n = 0; n < 3; n++) begin
              if (cap_ok[n]) ld_q[cap_idx[n][AW-1:0]] <= rd_in[n];
            end
          end
          addr_q <= beat_addr;
          elem_q <= beat_elem;
          if (beat_more) begin
            pos_q <= pos_d;
            wd_q  <= wd_d;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            oe_q    <= 1'b0;
            wen_q   <= 1'b0;
            for (int n = 0; n < 3; n++) begin
              pos_q[n] <= '0;
              wd_q[n]  <= '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a behavioural 3-port memory.
module tb_vector_mem_sequencer;

  logic          clk;
  logic          rst_n;
  logic          start, is_store;
  logic [15:0]   base, stride;
  logic [3:0]    vlen;
  logic [191:0]  stv;
  logic          busy, done, oe, wen;
  logic [191:0]  ldv;
  logic [15:0]   pos1, pos2, pos3, wd1, wd2, wd3, rd1, rd2, rd3;

  logic [15:0]   mem [65536];

  int n_pass  = 0;
  int n_total = 0;

  vector_mem_sequencer dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .start_i     (start),
    .is_store_i  (is_store),
    .base_addr_i (base),
    .stride_i    (stride),
    .vlen_i      (vlen),
    .st_vector_i (stv),
    .busy_o      (busy),
    .done_o      (done),
    .ld_vector_o (ldv),
    .mem_pos1_o  (pos1),
    .mem_pos2_o  (pos2),
    .mem_pos3_o  (pos3),
    .mem_wd1_o   (wd1),
    .mem_wd2_o   (wd2),
    .mem_wd3_o   (wd3),
    .mem_oe_o    (oe),
    .mem_wen_o   (wen),
    .mem_rd1_i   (rd1),
    .mem_rd2_i   (rd2),
    .mem_rd3_i   (rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, combinational read while oe high.
  always @(posedge clk) begin
    if (wen) begin
      mem[pos1] <= wd1;
      mem[pos2] <= wd2;
      mem[pos3] <= wd3;
    end
  end
  assign rd1 = oe ? mem[pos1] : 16'h0;
  assign rd2 = oe ? mem[pos2] : 16'h0;
  assign rd3 = oe ? mem[pos3] : 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Element i = b+i for i<n, zero above.
  function automatic logic [191:0] mkvec(input logic [15:0] b, input int n);
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) if (i < n) v[i*16 +: 16] = b + 16'(i);
    return v;
  endfunction

  task automatic req(input logic st, input logic [15:0] b, input logic [15:0] s,
                     input logic [3:0] n, input logic [191:0] d);
    start = 1'b1; is_store = st; base = b; stride = s; vlen = n; stv = d;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0;
    base = '0; stride = '0; vlen = '0; stv = '0;

    // 1: reset state
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_pos", {pos1, pos2, pos3}, 48'h0);
    chk("rst_ld", ldv, 192'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: store base 0 stride 4 vlen 7, with ignored start during beat 0 and DONE
    req(1'b1, 16'h0000, 16'd4, 4'd7, mkvec(16'h100, 12));
    chk("st_b0_busy", busy, 1'b1);
    chk("st_b0_wen_oe", {wen, oe}, 2'b10);
    chk("st_b0_pos", {pos1, pos2, pos3}, {16'd0, 16'd4, 16'd8});
    chk("st_b0_wd", {wd1, wd2, wd3}, {16'h100, 16'h101, 16'h102});
    start = 1'b1; is_store = 1'b0; base = 16'h500; vlen = 4'd3;
    tick();
    start = 1'b0;
    chk("st_b1_pos", {pos1, pos2, pos3}, {16'd12, 16'd16, 16'd20});
    chk("st_b1_wd", {wd1, wd2, wd3}, {16'h103, 16'h104, 16'h105});
    chk("st_b1_wen", wen, 1'b1);
    tick();
    chk("st_b2_pos", {pos1, pos2, pos3}, {16'd24, 16'd24, 16'd24});
    chk("st_b2_wd", {wd1, wd2, wd3}, {16'h106, 16'h106, 16'h106});
    chk("st_b2_done", done, 1'b0);
    tick();
    chk("st_done", done, 1'b1);
    chk("st_done_busy", busy, 1'b1);
    chk("st_done_wen", wen, 1'b0);
    chk("st_done_pos", pos1, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_idle_busy", busy, 1'b0);
    chk("st_idle_done", done, 1'b0);
    tick();
    chk("st_ign_busy", busy, 1'b0);

    // 3: load the same vector back
    req(1'b0, 16'h0000, 16'd4, 4'd7, '0);
    chk("ld_b0_oe_wen", {oe, wen}, 2'b10);
    chk("ld_b0_pos", {pos1, pos2, pos3}, {16'd0, 16'd4, 16'd8});
    tick();
    chk("ld_b1_oe", oe, 1'b1);
    tick();
    chk("ld_b2_pos", {pos1, pos2, pos3}, {16'd24, 16'd24, 16'd24});
    chk("ld_b2_oe_wen", {oe, wen}, 2'b10);
    tick();
    chk("ld_done", done, 1'b1);
    chk("ld_done_oe", oe, 1'b0);
    chk("ld_vec", ldv, mkvec(16'h100, 7));
    tick();
    chk("ld_hold_done", done, 1'b0);
    chk("ld_vec_hold", ldv, mkvec(16'h100, 7));

    // 4: address wrap
    req(1'b1, 16'hFFFE, 16'd1, 4'd3, mkvec(16'h0A0, 12));
    chk("wrap_pos", {pos1, pos2, pos3}, {16'hFFFE, 16'hFFFF, 16'h0000});
    chk("wrap_wd", {wd1, wd2, wd3}, {16'h0A0, 16'h0A1, 16'h0A2});
    chk("wrap_wen", wen, 1'b1);
    tick();
    chk("wrap_done", done, 1'b1);
    chk("wrap_ld_untouched", ldv, mkvec(16'h100, 7));
    tick();

    // 5a: zero-length request
    req(1'b1, 16'h0040, 16'd1, 4'd0, mkvec(16'h777, 12));
    chk("z_done", done, 1'b1);
    chk("z_busy", busy, 1'b1);
    chk("z_oe_wen", {oe, wen}, 2'b00);
    tick();
    chk("z_idle", {busy, done}, 2'b00);

    // 5b: vlen 15 clamps to 12 -> four beats
    req(1'b1, 16'h0200, 16'd1, 4'd15, mkvec(16'hA00, 12));
    chk("cl_b0_wen", wen, 1'b1);
    tick();
    tick();
    tick();
    chk("cl_b3_pos", {pos1, pos2, pos3}, {16'h209, 16'h20A, 16'h20B});
    chk("cl_b3_wd", {wd1, wd2, wd3}, {16'hA09, 16'hA0A, 16'hA0B});
    chk("cl_b3_wen", wen, 1'b1);
    tick();
    chk("cl_done", done, 1'b1);
    chk("cl_done_wen", wen, 1'b0);
    tick();

    req(1'b0, 16'h0200, 16'd1, 4'd15, '0);
    tick();
    tick();
    tick();
    tick();
    chk("cl_ld_done", done, 1'b1);
    chk("cl_ld_vec", ldv, mkvec(16'hA00, 12));
    tick();

    // short load clears elements beyond its length
    req(1'b0, 16'h0200, 16'd1, 4'd2, '0);
    chk("sh_pos", {pos1, pos2, pos3}, {16'h200, 16'h201, 16'h200});
    chk("sh_oe", oe, 1'b1);
    tick();
    chk("sh_done", done, 1'b1);
    chk("sh_vec", ldv, mkvec(16'hA00, 2));
    tick();

    // 6: reset during beat 1 of a store
    req(1'b1, 16'h0300, 16'd2, 4'd6, mkvec(16'hC00, 12));
    chk("ab_b0_wen", wen, 1'b1);
    tick();
    chk("ab_b1_pos", pos1, 16'h0306);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_wen_drop", wen, 1'b0);
    chk("ab_busy_drop", busy, 1'b0);
    chk("ab_pos_drop", pos1, 16'h0);
    chk("ab_ld_clear", ldv, 192'h0);
    tick();
    chk("ab_no_done_a", done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("ab_no_done_b", {busy, done}, 2'b00);
    tick();
    chk("ab_idle", {busy, done, wen, oe}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
